// File: rtl/stc0_pkg.sv
// rtl/stc0_pkg.sv - shared LFSR32 polynomial, predictor function and checker state type
// Purpose: single definition of the x^32+x^22+x^2+x+1 taps used by lfsr32 and
// lfsr32_checker, so generator and checker can never disagree on the polynomial.
// Ports: none (package).
package stc0_pkg;

    // Tap mask over the shift register (bit 0 = newest bit): s[31], s[21], s[1], s[0].
    localparam logic [31:0] LFSR32_TAPS = 32'h8020_0003;

    typedef enum logic [1:0] {
        SEED   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } chk_state_t;

    // Next bit the sequence must produce given the last 32 bits.
    function automatic logic lfsr32_pred(input logic [31:0] s);
        return ^(s & LFSR32_TAPS);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with synchronous clear
// Purpose: counts inc_i pulses, sticks at all-ones, clr_i wins over inc_i.
// Ports: clk_i clock, rst_i async active-high reset, clr_i sync clear,
//        inc_i increment strobe, count_o current count.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/lfsr32_checker.sv
// rtl/lfsr32_checker.sv - self-synchronising PRBS checker for the lfsr32 serial stream
// Purpose: fills a 32-bit history, self-syncs until LOCK_CNT consecutive bits are
// predicted, then flywheels on its own prediction, counting checked bits and errors,
// and drops back to SEED when LOSS_ERR errors land in one WINDOW-bit window.
// Ports: Clk clock, ARst async active-high reset, En bit-valid strobe, DIn received bit,
//        Clear sync clear of counters, Locked lock status, ErrPulse one-cycle error flag,
//        ErrCount / BitCount saturating error and checked-bit counts.
module lfsr32_checker
    import stc0_pkg::*;
#(
    parameter int LOCK_CNT = 64,
    parameter int WINDOW   = 256,
    parameter int LOSS_ERR = 8,
    parameter int CNT_W    = 32
) (
    input  logic             Clk,
    input  logic             ARst,
    input  logic             En,
    input  logic             DIn,
    input  logic             Clear,
    output logic             Locked,
    output logic             ErrPulse,
    output logic [CNT_W-1:0] ErrCount,
    output logic [CNT_W-1:0] BitCount
);

    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int WW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int EW = $clog2(LOSS_ERR + 1);
    localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_CNT - 1);
    localparam logic [WW-1:0] WIN_LAST   = WW'(WINDOW - 1);
    localparam logic [EW-1:0] LOSS_V     = EW'(LOSS_ERR);

    chk_state_t    state_q, state_d;
    logic [31:0]   s_q, s_d;
    logic [5:0]    fill_q, fill_d;
    logic [MW-1:0] match_q, match_d;
    logic [WW-1:0] win_cnt_q, win_cnt_d;
    logic [EW-1:0] win_err_q, win_err_d;
    logic          locked_q;
    logic          err_pulse_q, err_pulse_d;

    logic          pred;
    logic          mismatch;
    logic [31:0]   s_rx;
    logic [EW-1:0] win_err_base;
    logic          err_inc;
    logic          bit_inc;

    assign pred     = lfsr32_pred(s_q);
    assign mismatch = DIn ^ pred;
    assign s_rx     = {s_q[30:0], DIn};

    always_comb begin
        state_d      = state_q;
        s_d          = s_q;
        fill_d       = fill_q;
        match_d      = match_q;
        win_cnt_d    = win_cnt_q;
        win_err_d    = win_err_q;
        err_pulse_d  = 1'b0;
        err_inc      = 1'b0;
        bit_inc      = 1'b0;
        win_err_base = win_err_q;

        if (En) begin
            case (state_q)
                SEED: begin
                    s_d = s_rx;
                    if (fill_q == 6'd31) begin
                        state_d = SYNC;
                        fill_d  = '0;
                        match_d = '0;
                    end else begin
                        fill_d = fill_q + 6'd1;
                    end
                end
                SYNC: begin
                    s_d = s_rx;
                    if (mismatch) begin
                        match_d = '0;
                    end else if (match_q == MATCH_LAST) begin
                        // An all-zero history is a valid fixed point of the
                        // recurrence, so it would "lock" on a dead line; refuse it.
                        match_d = '0;
                        if (s_rx != '0) begin
                            state_d   = LOCKED;
                            win_cnt_d = '0;
                            win_err_d = '0;
                        end
                    end else begin
                        match_d = match_q + MW'(1);
                    end
                end
                LOCKED: begin
                    // Flywheel: history follows the prediction, so a received
                    // error is counted once and never re-enters the predictor.
                    s_d       = {s_q[30:0], pred};
                    bit_inc   = 1'b1;
                    win_cnt_d = win_cnt_q + WW'(1);
                    // The bit on which the window counter wraps opens the new window.
                    if (win_cnt_q == WIN_LAST) begin
                        win_err_base = '0;
                    end
                    win_err_d = win_err_base;
                    if (mismatch) begin
                        err_pulse_d = 1'b1;
                        err_inc     = 1'b1;
                        win_err_d   = win_err_base + EW'(1);
                        if (win_err_d == LOSS_V) begin
                            state_d   = SEED;
                            fill_d    = '0;
                            match_d   = '0;
                            win_cnt_d = '0;
                            win_err_d = '0;
                        end
                    end
                end
                default: begin
                    state_d = SEED;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or posedge ARst) begin
        if (ARst) begin
            state_q     <= SEED;
            s_q         <= '0;
            fill_q      <= '0;
            match_q     <= '0;
            win_cnt_q   <= '0;
            win_err_q   <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            fill_q      <= fill_d;
            match_q     <= match_d;
            win_cnt_q   <= win_cnt_d;
            win_err_q   <= win_err_d;
            locked_q    <= (state_d == LOCKED);
            err_pulse_q <= err_pulse_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk_i   (Clk),
        .rst_i   (ARst),
        .clr_i   (Clear),
        .inc_i   (err_inc),
        .count_o (ErrCount)
    );

    sat_counter #(.W(CNT_W)) u_bit_cnt (
        .clk_i   (Clk),
        .rst_i   (ARst),
        .clr_i   (Clear),
        .inc_i   (bit_inc),
        .count_o (BitCount)
    );

    assign Locked   = locked_q;
    assign ErrPulse = err_pulse_q;

endmodule

// File: tb/tb_lfsr32_checker.sv
// tb/tb_lfsr32_checker.sv - self-checking bench for lfsr32_checker
module tb_lfsr32_checker;

    logic        Clk = 1'b0;
    logic        ARst, En, DIn, DIn2, Clear;
    logic        Locked, ErrPulse, Locked2, ErrPulse2;
    logic [31:0] ErrCount, BitCount;
    logic [3:0]  ErrCount2, BitCount2;

    always #5 Clk = ~Clk;

    lfsr32_checker #(.LOCK_CNT(64), .WINDOW(256), .LOSS_ERR(8), .CNT_W(32)) dut (
        .Clk(Clk), .ARst(ARst), .En(En), .DIn(DIn), .Clear(Clear),
        .Locked(Locked), .ErrPulse(ErrPulse), .ErrCount(ErrCount), .BitCount(BitCount)
    );

    lfsr32_checker #(.LOCK_CNT(64), .WINDOW(256), .LOSS_ERR(256), .CNT_W(4)) dut2 (
        .Clk(Clk), .ARst(ARst), .En(En), .DIn(DIn2), .Clear(Clear),
        .Locked(Locked2), .ErrPulse(ErrPulse2), .ErrCount(ErrCount2), .BitCount(BitCount2)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Stream source: first 32 bits are the seed, then b[n]=b[n-1]^b[n-2]^b[n-22]^b[n-32].
    logic [31:0] gseed;
    int          gcount;
    bit          gh[32];

    task automatic gen_bit(output bit b);
        if (gcount < 32) b = gseed[gcount];
        else b = gh[(gcount-1)%32] ^ gh[(gcount-2)%32] ^ gh[(gcount-22)%32] ^ gh[(gcount-32)%32];
        gh[gcount%32] = b;
        gcount++;
    endtask

    // Reference model: one entry per DUT. Modes 0/1/2 = filling, hunting, locked.
    int     m_mode[2], m_fill[2], m_run[2], m_lk[2], m_win[2], m_werr[2], mpos[2];
    longint m_errc[2], m_bitc[2];
    bit     m_pulse[2];
    bit     mh[2][32];
    int     m_loss[2];
    longint m_max[2];

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_mode[m] = 0; m_fill[m] = 0; m_run[m] = 0; m_lk[m] = 0;
            m_win[m] = 0; m_werr[m] = 0; mpos[m] = 0;
            m_errc[m] = 0; m_bitc[m] = 0; m_pulse[m] = 0;
            for (int i = 0; i < 32; i++) mh[m][i] = 0;
        end
    endtask

    task automatic model_step(input int m, input bit en, input bit din, input bit clr);
        bit pred, allz;
        int wid;
        m_pulse[m] = 0;
        if (en) begin
            pred = mh[m][(mpos[m]+31)%32] ^ mh[m][(mpos[m]+30)%32]
                 ^ mh[m][(mpos[m]+10)%32] ^ mh[m][mpos[m]];
            mh[m][mpos[m]] = (m_mode[m] == 2) ? pred : din;
            mpos[m] = (mpos[m] + 1) % 32;
            if (m_mode[m] == 0) begin
                m_fill[m]++;
                if (m_fill[m] == 32) begin m_mode[m] = 1; m_run[m] = 0; end
            end else if (m_mode[m] == 1) begin
                m_run[m] = (din == pred) ? m_run[m] + 1 : 0;
                if (m_run[m] == 64) begin
                    allz = 1;
                    for (int i = 0; i < 32; i++) if (mh[m][i]) allz = 0;
                    m_run[m] = 0;
                    if (!allz) begin m_mode[m] = 2; m_lk[m] = 0; m_win[m] = 0; m_werr[m] = 0; end
                end
            end else begin
                if (m_bitc[m] < m_max[m]) m_bitc[m]++;
                wid = (m_lk[m] + 1) / 256;
                if (wid != m_win[m]) begin m_win[m] = wid; m_werr[m] = 0; end
                m_lk[m]++;
                if (din != pred) begin
                    m_pulse[m] = 1;
                    if (m_errc[m] < m_max[m]) m_errc[m]++;
                    m_werr[m]++;
                    if (m_werr[m] == m_loss[m]) begin m_mode[m] = 0; m_fill[m] = 0; m_run[m] = 0; end
                end
            end
        end
        if (clr) begin m_errc[m] = 0; m_bitc[m] = 0; end
    endtask

    task automatic cmp_all();
        check("locked",    Locked,    m_mode[0] == 2);
        check("errpulse",  ErrPulse,  m_pulse[0]);
        check("errcount",  ErrCount,  m_errc[0]);
        check("bitcount",  BitCount,  m_bitc[0]);
        check("locked2",   Locked2,   m_mode[1] == 2);
        check("errpulse2", ErrPulse2, m_pulse[1]);
        check("errcount2", ErrCount2, m_errc[1]);
        check("bitcount2", BitCount2, m_bitc[1]);
    endtask

    task automatic step(input bit en, input bit f1, input bit f2, input bit clr);
        bit b;
        @(negedge Clk);
        if (en) gen_bit(b);
        else b = 1'($urandom_range(0, 1));
        En = en; DIn = b ^ f1; DIn2 = b ^ f2; Clear = clr;
        @(posedge Clk);
        #1;
        model_step(0, en, b ^ f1, clr);
        model_step(1, en, b ^ f2, clr);
        cmp_all();
    endtask

    task automatic do_reset(input logic [31:0] seed);
        @(negedge Clk);
        ARst = 1; Clear = 0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            En = ~En; DIn = 1'($urandom_range(0, 1)); DIn2 = DIn;
        end
        check("rst_locked", Locked, 0);
        check("rst_pulse",  ErrPulse, 0);
        check("rst_err",    ErrCount, 0);
        check("rst_bits",   BitCount, 0);
        gseed = seed; gcount = 0;
        @(negedge Clk);
        ARst = 0; En = 0;
    endtask

    // Counts En bits until Locked is seen; period 1 = every cycle, 3 = 1-in-3.
    task automatic acquire(input int period, output int nbits);
        nbits = 0;
        for (int i = 0; i < 2000; i++) begin
            step((i % period) == 0, 0, 0, 0);
            if ((i % period) == 0) nbits++;
            if (Locked) break;
        end
    endtask

    task automatic align(input int t);
        for (int i = 0; i < 600 && (m_lk[0] % 256) != t; i++) step(1, 0, 0, 0);
        check("align_bound", m_lk[0] % 256, t);
    endtask

    int n, pulses, seen;

    initial begin
        ARst = 1; En = 0; DIn = 0; DIn2 = 0; Clear = 0;
        m_loss[0] = 8;  m_max[0] = 64'hFFFF_FFFF;
        m_loss[1] = 256; m_max[1] = 15;
        model_reset();

        // Reset then acquire from seed 1
        do_reset(32'h0000_0001);
        acquire(1, n);
        check("acq_bits", n, 96);
        check("acq_err", ErrCount, 0);

        // Single flip at stream bit 200
        pulses = 0;
        for (int i = 0; i < 300; i++) begin
            step(1, gcount == 199, gcount == 199, 0);
            pulses += int'(ErrPulse);
        end
        check("flip_pulses", pulses, 1);
        check("flip_err", ErrCount, 1);
        check("flip_locked", Locked, 1);

        // Eight errors in one window -> loss, then relock
        step(1, 0, 0, 1);
        align(10);
        for (int k = 0; k < 8; k++) begin
            repeat ($urandom_range(0, 23)) step(1, 0, 0, 0);
            step(1, 1, 1, 0);
        end
        check("loss_locked", Locked, 0);
        check("loss_pulse", ErrPulse, 1);
        check("loss_err", ErrCount, 8);
        acquire(1, n);
        check("relock_bits", n, 96);
        check("relock_err", ErrCount, 8);

        // Seven in one window, one in the next -> stays locked
        step(1, 0, 0, 1);
        align(100);
        for (int k = 0; k < 7; k++) begin
            repeat ($urandom_range(0, 19)) step(1, 0, 0, 0);
            step(1, 1, 1, 0);
        end
        align(20);
        step(1, 1, 1, 0);
        check("split_locked", Locked, 1);
        check("split_err", ErrCount, 8);

        // Clear on the same cycle as an error
        step(1, 1, 1, 1);
        check("clr_pulse", ErrPulse, 1);
        check("clr_err", ErrCount, 0);

        // Narrow counter saturates
        for (int k = 0; k < 20; k++) begin
            repeat ($urandom_range(1, 9)) step(1, 0, 0, 0);
            step(1, 0, 1, 0);
        end
        check("sat_err2", ErrCount2, 15);
        check("sat_locked2", Locked2, 1);
        check("sat_err_main", ErrCount, 0);

        // Asynchronous reset while hunting with non-zero counters
        align(50);
        repeat (8) step(1, 1, 0, 0);
        check("pre_arst_err", ErrCount, 8);
        repeat (50) step(1, 0, 0, 0);
        @(negedge Clk);
        #2 ARst = 1;
        #1;
        check("arst_locked", Locked, 0);
        check("arst_pulse", ErrPulse, 0);
        check("arst_err", ErrCount, 0);
        check("arst_bits", BitCount, 0);
        check("arst_err2", ErrCount2, 0);
        model_reset();
        @(negedge Clk);
        ARst = 0; En = 0;

        // All-zero line never locks
        do_reset(32'h0);
        seen = 0;
        for (int i = 0; i < 400; i++) begin
            step(1, 0, 0, 0);
            seen += int'(Locked);
        end
        check("zero_never_locks", seen, 0);

        // 1-in-3 En with a random seed, then a random soak
        do_reset($urandom | 32'h1);
        acquire(3, n);
        check("gap_acq_bits", n, 96);
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 2) != 0, $urandom_range(0, 99) == 0,
                 $urandom_range(0, 49) == 0, $urandom_range(0, 199) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
